tcm_axis_frame_src: RTL and testbench

AXI-Stream master that plays a frame out of a 32-entry local buffer into the TCM capture slave downstream. Software loads the buffer through a simple write port, then a control-register start edge streams 1..32 beats with TLAST on the final beat. Output is buffered, so the stream runs at one beat per clock under continuous TREADY and holds cleanly under backpressure.

---
 rtl/tcm_axis_pkg.sv | 33 +++
 rtl/tcm_axis_frame_src_if.sv | 24 ++
 rtl/tcm_axis_skid_fifo.sv | 52 +++++
 rtl/tcm_axis_frame_src.sv | 178 +++++++++++++++++
 tb/tb_tcm_axis_frame_src.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/tcm_axis_pkg.sv
// ----------------------------------------------------------------------------
// tcm_axis_pkg
// Shared constants and types for the TCM AXI-Stream frame source:
//   - control/status register bit positions
//   - default stream width and buffer depth
//   - frame FSM state encoding
// Optional feature macro used elsewhere in this slice: TCM_AXIS_SRC_PATTERN_EN
// ----------------------------------------------------------------------------
package tcm_axis_pkg;

   // USR_frame_control bit positions
   localparam int unsigned CTRL_START   = 0;
   localparam int unsigned CTRL_LEN_LSB = 2;
   localparam int unsigned CTRL_LEN_MSB = 6;
   localparam int unsigned CTRL_PATTERN = 7;

   // USR_frame_status bit positions
   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_DONE    = 1;
   localparam int unsigned STAT_CNT_LSB = 8;
   localparam int unsigned STAT_CNT_MSB = 15;

   // Defaults
   localparam int unsigned DEF_TDATA_WIDTH = 32;
   localparam int unsigned DEF_DEPTH       = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/tcm_axis_frame_src_if.sv
// ----------------------------------------------------------------------------
// tcm_axis_frame_src_if
// AXI-Stream bundle between the frame source (master) and the TCM capture
// slave.
//   TVALID  master->slave  beat valid
//   TDATA   master->slave  beat data (DATA_W bits)
//   TSTRB   master->slave  byte strobes (DATA_W/8 bits)
//   TLAST   master->slave  final beat of frame
//   TREADY  slave->master  downstream ready
// ----------------------------------------------------------------------------
interface tcm_axis_frame_src_if
   import tcm_axis_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_TDATA_WIDTH
);
   logic              TVALID;
   logic [DATA_W-1:0] TDATA;
   logic [DATA_W/8-1:0] TSTRB;
   logic              TLAST;
   logic              TREADY;

   modport master (output TVALID, output TDATA, output TSTRB, output TLAST, input TREADY);
   modport slave  (input TVALID, input TDATA, input TSTRB, input TLAST, output TREADY);
endinterface

// File: rtl/tcm_axis_skid_fifo.sv
// ----------------------------------------------------------------------------
// tcm_axis_skid_fifo
// Two-entry FIFO holding {TLAST, TDATA} beats in front of the stream port.
//   i_clk    clock
//   i_flush  synchronous active-high flush (empties FIFO, zeroes storage)
//   i_push   write i_data (caller guarantees not full unless popping)
//   i_data   entry to write
//   i_pop    drop head entry (caller guarantees not empty)
//   o_data   head entry, stable until popped
//   o_full   two entries held
//   o_empty  no entries held
// ----------------------------------------------------------------------------
module tcm_axis_skid_fifo #(
   parameter int unsigned W = 33
) (
   input  logic         i_clk,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   logic [W-1:0] r_mem [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;

   always_ff @(posedge i_clk) begin
      if (i_flush) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + 2'(i_push) - 2'(i_pop);
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
endmodule

// File: rtl/tcm_axis_frame_src.sv
// ----------------------------------------------------------------------------
// tcm_axis_frame_src
// Plays a 1..C_DEPTH beat frame from a local buffer out on AXI-Stream.
// Software loads the buffer through the USR_wr_* port, then a rising edge on
// control bit 0 streams the frame with TLAST on the final beat.
//   M_AXIS_ACLK        clock
//   M_AXIS_ARESET      synchronous active-high reset (buffer is preserved)
//   USR_frame_control  [0] start edge, [6:2] length-1, [7] pattern mode
//   USR_frame_status   [0] busy, [1] done (sticky), [15:8] frame count
//   USR_wr_en/addr/data buffer write port, accepted in every state
//   M_AXIS             AXI-Stream master (TVALID/TDATA/TSTRB/TLAST/TREADY)
// Optional macro: TCM_AXIS_SRC_PATTERN_EN builds the beat-index pattern mux.
// ----------------------------------------------------------------------------
module tcm_axis_frame_src
   import tcm_axis_pkg::*;
#(
   parameter  int unsigned C_M_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
   parameter  int unsigned C_DEPTH              = DEF_DEPTH,
   localparam int unsigned ADDR_W               = $clog2(C_DEPTH)
) (
   input  logic                            M_AXIS_ACLK,
   input  logic                            M_AXIS_ARESET,
   input  logic [31:0]                     USR_frame_control,
   output logic [31:0]                     USR_frame_status,
   input  logic                            USR_wr_en,
   input  logic [ADDR_W-1:0]               USR_wr_addr,
   input  logic [C_M_AXIS_TDATA_WIDTH-1:0] USR_wr_data,
   tcm_axis_frame_src_if.master            M_AXIS
);
   localparam int unsigned W = C_M_AXIS_TDATA_WIDTH;

   logic [W-1:0]      r_mem [C_DEPTH];
   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_start_q;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] r_last_addr;
   logic              r_rd_vld;
   logic              r_rd_last;
   logic [W-1:0]      r_rd_data;
   logic              r_done;
   logic [7:0]        r_frame_cnt;

   logic              w_start_edge;
   logic              w_rd_issue;
   logic              w_frame_done;
   logic              w_pop;
   logic [1:0]        w_fifo_cnt;
   logic [2:0]        w_occ;
   logic [W-1:0]      w_rd_word;
   logic [W:0]        w_fifo_dout;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic              w_unused;

   // Reserved control bits; bit 7 is folded in too since it is unused in
   // the default build.
   assign w_unused = &{1'b0, USR_frame_control[31:8], USR_frame_control[CTRL_PATTERN],
                       USR_frame_control[1]};

   assign w_start_edge = USR_frame_control[CTRL_START] & ~r_start_q;
   assign w_pop        = ~w_fifo_empty & M_AXIS.TREADY;
   assign w_fifo_cnt   = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
   // Occupancy counts the beat leaving this cycle as already gone so a read
   // can be issued every cycle under continuous TREADY.
   assign w_occ        = {1'b0, w_fifo_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};

   // Buffer write port; no reset so contents survive M_AXIS_ARESET.
   always_ff @(posedge M_AXIS_ACLK) begin
      if (USR_wr_en) begin
         r_mem[USR_wr_addr] <= USR_wr_data;
      end
   end

`ifdef TCM_AXIS_SRC_PATTERN_EN
   logic r_pattern;

   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         r_pattern <= 1'b0;
      end else if (r_state == IDLE && w_start_edge) begin
         r_pattern <= USR_frame_control[CTRL_PATTERN];
      end
   end

   assign w_rd_word = r_pattern ? W'(r_rd_addr) : r_mem[r_rd_addr];
`else
   assign w_rd_word = r_mem[r_rd_addr];
`endif

   // FSM: state register
   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start_edge) w_state_nxt = RUN;
         RUN:     if (w_rd_issue && r_rd_addr == r_last_addr) w_state_nxt = DRAIN;
         DRAIN:   if (w_frame_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_rd_issue   = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         RUN:     w_rd_issue   = (w_occ < 3'd2);
         DRAIN:   w_frame_done = w_pop & w_fifo_dout[W];
         default: ;
      endcase
   end

   // Read pipeline, edge detector and status
   always_ff @(posedge M_AXIS_ACLK) begin
      if (M_AXIS_ARESET) begin
         r_start_q   <= 1'b0;
         r_rd_addr   <= '0;
         r_last_addr <= '0;
         r_rd_vld    <= 1'b0;
         r_rd_last   <= 1'b0;
         r_rd_data   <= '0;
         r_done      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_start_q <= USR_frame_control[CTRL_START];
         r_rd_vld  <= w_rd_issue;
         if (r_state == IDLE && w_start_edge) begin
            r_last_addr <= ADDR_W'(USR_frame_control[CTRL_LEN_MSB:CTRL_LEN_LSB]);
            r_rd_addr   <= '0;
            r_done      <= 1'b0;
         end
         if (w_rd_issue) begin
            r_rd_addr <= r_rd_addr + 1'b1;
            r_rd_last <= (r_rd_addr == r_last_addr);
            r_rd_data <= w_rd_word;
         end
         if (w_frame_done) begin
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   tcm_axis_skid_fifo #(
      .W (W + 1)
   ) u_fifo (
      .i_clk   (M_AXIS_ACLK),
      .i_flush (M_AXIS_ARESET),
      .i_push  (r_rd_vld),
      .i_data  ({r_rd_last, r_rd_data}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_comb begin
      USR_frame_status                            = '0;
      USR_frame_status[STAT_BUSY]                 = (r_state != IDLE);
      USR_frame_status[STAT_DONE]                 = r_done;
      USR_frame_status[STAT_CNT_MSB:STAT_CNT_LSB] = r_frame_cnt;
   end

   // Data/last forced to zero while idle so the bus is quiet between frames.
   assign M_AXIS.TVALID = ~w_fifo_empty;
   assign M_AXIS.TDATA  = w_fifo_empty ? '0 : w_fifo_dout[W-1:0];
   assign M_AXIS.TLAST  = ~w_fifo_empty & w_fifo_dout[W];
   assign M_AXIS.TSTRB  = '1;
endmodule

// File: tb/tb_tcm_axis_frame_src.sv
// ----------------------------------------------------------------------------
// tb_tcm_axis_frame_src
// Directed bench for tcm_axis_frame_src: buffer load, continuous and
// throttled frames, min/max length, start-edge filtering, mid-frame reset and
// (with TCM_AXIS_SRC_PATTERN_EN) pattern mode.
// ----------------------------------------------------------------------------
module tb_tcm_axis_frame_src;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ctrl;
   logic [31:0] status;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        tready;
   int          total = 0;
   int          bad   = 0;

   tcm_axis_frame_src_if #(.DATA_W(32)) m_if ();
   assign m_if.TREADY = tready;

   tcm_axis_frame_src #(
      .C_M_AXIS_TDATA_WIDTH (32),
      .C_DEPTH              (32)
   ) dut (
      .M_AXIS_ACLK       (clk),
      .M_AXIS_ARESET     (rst),
      .USR_frame_control (ctrl),
      .USR_frame_status  (status),
      .USR_wr_en         (wr_en),
      .USR_wr_addr       (wr_addr),
      .USR_wr_data       (wr_data),
      .M_AXIS            (m_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag, input logic [7:0] cnt);
      chk(tag, status, {16'h0, cnt, 8'h02});
   endtask

   // Drops start for one cycle, then raises it (with fields) and holds it.
   task automatic start_frame(input logic [31:0] v);
      @(negedge clk);
      ctrl = 32'h0;
      @(negedge clk);
      ctrl = v | 32'h1;
   endtask

   // Called at a negedge. Each negedge: choose TREADY for the coming edge,
   // check the presented beat, count a handshake. Stalled beats are rechecked
   // against the same expected value, so holding and no-repeat are covered.
   task automatic collect(input int n, input bit pat, input bit toggle);
      int k = 0;
      int cyc = 0;
      bit started = 0;
      bit stalled = 0;
      logic [31:0] exp_d;
      while (k < n && cyc < 400) begin
         if (toggle) tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         else        tready = 1'b1;
         if (m_if.TVALID) begin
            started = 1;
            exp_d = pat ? 32'(k) : (32'hA000 + 32'(k));
            chk("beat_data", m_if.TDATA, exp_d);
            chk("beat_last", 32'(m_if.TLAST), 32'(k == n - 1));
            stalled = !tready;
            if (tready) k++;
         end else begin
            if (stalled || (started && !toggle))
               chk("valid_cont", 32'(m_if.TVALID), 32'h1);
            stalled = 0;
         end
         cyc++;
         if (k < n) @(negedge clk);
      end
      if (k < n) chk("beats_timeout", 32'(k), 32'(n));
      tready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; ctrl = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; tready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 32'(m_if.TVALID), 32'h0);
      chk("rst_tdata",  m_if.TDATA,         32'h0);
      chk("rst_tlast",  32'(m_if.TLAST),  32'h0);
      chk("rst_tstrb",  32'(m_if.TSTRB),  32'hF);
      chk("rst_status", status,             32'h0);
      rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'hA000 + 32'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;

      // Frame 1: len 8, continuous ready, first-beat latency
      start_frame(32'h1C);
      @(negedge clk);
      chk("f1_busy", status, 32'h1);
      chk("f1_lat_e0", 32'(m_if.TVALID), 32'h0);
      @(negedge clk);
      chk("f1_lat_e1", 32'(m_if.TVALID), 32'h0);
      @(negedge clk);
      chk("f1_lat_e2", 32'(m_if.TVALID), 32'h1);
      collect(8, 0, 0);
      @(negedge clk);
      check_status("f1_status", 8'd1);
      chk("f1_idle_tvalid", 32'(m_if.TVALID), 32'h0);

      // Frame 2: same frame with TREADY 1,0,0,1,...
      start_frame(32'h1C);
      @(negedge clk);
      collect(8, 0, 1);
      @(negedge clk);
      check_status("f2_status", 8'd2);

      // Frame 3: single beat
      start_frame(32'h00);
      @(negedge clk);
      collect(1, 0, 0);
      @(negedge clk);
      check_status("f3_status", 8'd3);

      // Frame 4: full 32 beats
      start_frame(32'h7C);
      @(negedge clk);
      collect(32, 0, 0);
      @(negedge clk);
      check_status("f4_status", 8'd4);

      // Frame 5: start level held through and beyond the frame
      start_frame(32'h1C);
      @(negedge clk);
      collect(8, 0, 0);
      @(negedge clk);
      check_status("f5_status", 8'd5);
      repeat (4) @(negedge clk);
      chk("f5_no_retrigger", 32'(m_if.TVALID), 32'h0);
      check_status("f5_status_hold", 8'd5);

      // Frame 6: start pulsed again mid-frame under backpressure
      start_frame(32'h1C);
      tready = 1'b0;
      repeat (3) @(negedge clk);
      ctrl = 32'h0;
      @(negedge clk);
      ctrl = 32'h1D;
      @(negedge clk);
      ctrl = 32'h0;
      @(negedge clk);
      collect(8, 0, 0);
      @(negedge clk);
      check_status("f6_status", 8'd6);
      repeat (5) @(negedge clk);
      chk("f6_single_frame", 32'(m_if.TVALID), 32'h0);

      // Frame 7: reset while beat 3 is presented, then replay
      start_frame(32'h1C);
      @(negedge clk);
      repeat (5) @(negedge clk);
      chk("f7_beat3", m_if.TDATA, 32'hA003);
      rst = 1'b1; ctrl = 32'h0;
      @(negedge clk);
      chk("f7_rst_tvalid", 32'(m_if.TVALID), 32'h0);
      chk("f7_rst_tlast",  32'(m_if.TLAST),  32'h0);
      chk("f7_rst_status", status,             32'h0);
      rst = 1'b0;
      start_frame(32'h1C);
      @(negedge clk);
      collect(8, 0, 0);
      @(negedge clk);
      check_status("f7_status", 8'd1);

      // Frame 8: pattern bit set, len 4
      start_frame(32'h8C);
      @(negedge clk);
`ifdef TCM_AXIS_SRC_PATTERN_EN
      collect(4, 1, 0);
`else
      collect(4, 0, 0);
`endif
      @(negedge clk);
      check_status("f8_status", 8'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
